timer_req_master: RTL and testbench
===================================

Name: timer_req_master

Overview:
Bus-side initiator for the 32-bit timer peripheral register. The register holds the period in [3:0] and the END flag in bit 4.
- Accepts a period request from a client over a valid/ready handshake.
- Writes the period into the timer register, then polls the END flag.
- Clears the register and returns a one-cycle done pulse with status.
- Sits between a client (CPU-side sequencer or another peripheral) and the timer block's WE/Entrada/Salida interface.

Parameters:
PERIOD_W, 4, width of the period field (register bits [PERIOD_W-1:0])
END_BIT, 4, bit position of the END flag in the timer register
TIMEOUT_CYC, 200000000, maximum poll cycles before abandoning the wait; must be >= 2

Ports:
clk  input  1  system clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  client request strobe
req_period  input  PERIOD_W  requested period, in timer ticks
req_ready  output  1  high only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
timed_out  output  1  status bit, valid while done=1
timer_we  output  1  write enable to the timer register
timer_wdata  output  32  write data to the timer register
timer_rdata  input  32  timer register read value (Salida)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - req_ready=1; busy=0; done=0; timed_out=0; timer_we=0; timer_wdata=0.
  - Latched period and watchdog counter are cleared.
- States and transitions:
  - IDLE: req_ready=1. On req_valid at a clk edge, latch req_period. If req_period==0, go to DONE with timed_out=0 and no timer write. Otherwise go to WRITE.
  - WRITE: timer_we=1; timer_wdata = zeros, END bit 0, period in the low field. Next state is ARM.
  - ARM: one cycle for register write latency; timer_rdata is ignored. Next state is POLL. The watchdog counter is zeroed.
  - POLL: if timer_rdata[END_BIT]=1, go to CLEAR with timed_out=0. Else, if counter==TIMEOUT_CYC-1, go to CLEAR with timed_out=1. Else increment the counter.
  - CLEAR: timer_we=1, timer_wdata=0 (clears END and period). Next state is DONE.
  - DONE: done=1 for exactly one cycle; timed_out is held valid. Next state is IDLE.
- Latency:
  - Request accepted at edge 0.
  - WRITE in cycle 1, ARM in cycle 2, first POLL in cycle 3.
  - END sampled high in POLL cycle n gives CLEAR in n+1 and done in n+2.
  - A zero-period request gives done in cycle 1.
- req_valid while busy is ignored; no queuing. The client must hold req_valid until it sees req_ready.
- A stale END=1 present before WRITE is never seen as completion, because ARM masks the first read-back.
- Watchdog counter is 32 bits, saturates, and is only active in POLL.
- timed_out keeps its last value until the next DONE; it is cleared on reset.
- Reset mid-operation:
  - Immediate return to IDLE; no CLEAR write is issued.
  - The timer register shares rst, so it is cleared by the same reset.
- timer_wdata bits other than the period field are always 0.

Optional Feature:
Macro TIMER_REQ_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in WRITE, ARM or POLL sends the next state to CLEAR and sets timed_out=1. An aborted WRITE still completes its write cycle first.
  - abort in IDLE, CLEAR or DONE has no effect.
- When undefined: no abort port and no abort logic; the behaviour is exactly as above.

Decomposition:
- Shared package timer_req_pkg holds:
  - state encoding (IDLE, WRITE, ARM, POLL, CLEAR, DONE, 3 bits)
  - TIMER_END_BIT=4, TIMER_PERIOD_MSB=3, TIMER_PERIOD_LSB=0
  - the TIMER_REG_W=32 constant
- One natural sub-module, timer_req_watchdog: a saturating 32-bit counter with clear and enable inputs and a terminal-count output compared against TIMEOUT_CYC-1.

Test Plan:
1. Reset with rst=1 for 2 cycles → all outputs at reset values, req_ready=1, timer_we=0.
2. Request req_period=4'd5; model sets END=1 six cycles after the write → timer_we=1 with wdata=32'h5 in cycle 1, timer_we=1 with wdata=0 in the CLEAR cycle, then done=1 with timed_out=0.
3. TIMEOUT_CYC=20, req_period=4'd3, END never set → exactly 20 POLL cycles, then CLEAR, then done=1 with timed_out=1.
4. req_period=0 → done=1 in cycle 1, timed_out=0, timer_we never asserted.
5. END preset to 1 before the request; request req_period=4'd2 → END is not recognised in ARM; completion only after the model re-raises END.
6. rst asserted in POLL, then a new request 4'd7 → IDLE next cycle with no CLEAR write; the new request completes normally. With TIMER_REQ_ABORT_EN, abort in POLL → CLEAR, then done with timed_out=1.

Source files
------------

// File: rtl/timer_req_pkg.sv
// Shared definitions for the timer request master: FSM state encoding and
// the timer register layout (period in the low field, END flag above it).
package timer_req_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    ARM   = 3'd2,
    POLL  = 3'd3,
    CLEAR = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam int TIMER_REG_W      = 32;
  localparam int TIMER_END_BIT    = 4;
  localparam int TIMER_PERIOD_MSB = 3;
  localparam int TIMER_PERIOD_LSB = 0;

endpackage

// File: rtl/timer_req_watchdog.sv
// Saturating poll-cycle counter; tc flags that the last allowed poll cycle
// (count == TIMEOUT_CYC-1) is in progress.
module timer_req_watchdog
  import timer_req_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 200000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TIMER_REG_W-1:0] TC_VAL = TIMER_REG_W'(TIMEOUT_CYC - 1);

  logic [TIMER_REG_W-1:0] cnt_q;
  logic [TIMER_REG_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/timer_req_master.sv
// Client-to-timer initiator: writes a period, polls END, clears the register
// and pulses done. Optional abort input enabled by TIMER_REQ_ABORT_EN.
module timer_req_master
  import timer_req_pkg::*;
#(
  parameter int          PERIOD_W    = 4,
  parameter int          END_BIT     = TIMER_END_BIT,
  parameter int unsigned TIMEOUT_CYC = 200000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [PERIOD_W-1:0]    req_period,
  output logic                   req_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   timed_out,
  output logic                   timer_we,
  output logic [TIMER_REG_W-1:0] timer_wdata,
`ifdef TIMER_REQ_ABORT_EN
  input  logic                   abort,
`endif
  input  logic [TIMER_REG_W-1:0] timer_rdata
);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                to_pend_q, to_pend_d;
  logic                timed_out_q, timed_out_d;
  logic                wd_clr, wd_en, wd_tc;
  logic                abort_hit;
  logic                rdata_unused;

`ifdef TIMER_REQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Only the END bit of the read-back matters.
  assign rdata_unused = ^timer_rdata;

  timer_req_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk(clk),
    .rst(rst),
    .clr(wd_clr),
    .en (wd_en),
    .tc (wd_tc)
  );

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    to_pend_d   = to_pend_q;
    timed_out_d = timed_out_q;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          period_d = req_period;
          if (req_period == '0) begin
            state_d     = DONE;
            timed_out_d = 1'b0;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        state_d = ARM;
        if (abort_hit) begin
          state_d   = CLEAR;
          to_pend_d = 1'b1;
        end
      end
      ARM: begin
        // Read-back here may still show a stale END; it is deliberately ignored.
        wd_clr  = 1'b1;
        state_d = POLL;
        if (abort_hit) begin
          state_d   = CLEAR;
          to_pend_d = 1'b1;
        end
      end
      POLL: begin
        if (abort_hit) begin
          state_d   = CLEAR;
          to_pend_d = 1'b1;
        end else if (timer_rdata[END_BIT]) begin
          state_d   = CLEAR;
          to_pend_d = 1'b0;
        end else if (wd_tc) begin
          state_d   = CLEAR;
          to_pend_d = 1'b1;
        end else begin
          wd_en = 1'b1;
        end
      end
      CLEAR: begin
        // Status becomes visible together with done and holds until the next one.
        state_d     = DONE;
        timed_out_d = to_pend_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      period_q    <= '0;
      to_pend_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      to_pend_q   <= to_pend_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign timed_out   = timed_out_q;
  assign timer_we    = (state_q == WRITE) || (state_q == CLEAR);
  assign timer_wdata = (state_q == WRITE) ?
                       {{(TIMER_REG_W-PERIOD_W){1'b0}}, period_q} : '0;

endmodule

// File: tb/tb_timer_req_master.sv
// Bench for timer_req_master with a behavioural timer register model whose
// read-back lags the register by one cycle.
module tb_timer_req_master;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_period;
  logic        req_ready, busy, done, timed_out, timer_we;
  logic [31:0] timer_wdata;
  logic [31:0] timer_rdata;
`ifdef TIMER_REQ_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_req_master #(
    .PERIOD_W(4),
    .END_BIT(4),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_period(req_period),
    .req_ready(req_ready),
    .busy(busy),
    .done(done),
    .timed_out(timed_out),
    .timer_we(timer_we),
    .timer_wdata(timer_wdata),
`ifdef TIMER_REQ_ABORT_EN
    .abort(abort),
`endif
    .timer_rdata(timer_rdata)
  );

  // Timer register model: END rises end_delay cycles after a nonzero-period write.
  logic [31:0] treg;
  int          since;
  logic        armed;
  logic        stale_set = 1'b0;
  int          end_delay = 0;

  always @(posedge clk) begin
    if (rst) begin
      treg        <= '0;
      timer_rdata <= '0;
      since       <= 0;
      armed       <= 1'b0;
    end else begin
      timer_rdata <= treg;
      if (timer_we) begin
        treg  <= timer_wdata;
        since <= 1;
        armed <= (timer_wdata[3:0] != 4'd0);
      end else begin
        if (since < 1000) since <= since + 1;
        if (stale_set) treg[4] <= 1'b1;
        else if (armed && end_delay > 0 && since == end_delay) treg[4] <= 1'b1;
      end
    end
  end

  // One request; expectations come from the cycle rules: write in cycle 1,
  // polls from cycle 3, END seen in cycle d+3, done two cycles after detection.
  task automatic run_req(input logic [3:0] p, input int d, input bit hold, input string name);
    int   exp_done, exp_wr, done_c, wr_n;
    logic exp_to, to_seen, hs_bad;
    if (p == 4'd0) begin
      exp_done = 1; exp_to = 1'b0; exp_wr = 0;
    end else if (d > 0 && d + 3 <= T + 2) begin
      exp_done = d + 5; exp_to = 1'b0; exp_wr = 2;
    end else begin
      exp_done = T + 4; exp_to = 1'b1; exp_wr = 2;
    end
    end_delay = d;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before: got %b want 1", name, req_ready);
    end
    req_valid  = 1'b1;
    req_period = p;
    done_c = 0; wr_n = 0; to_seen = 1'b0; hs_bad = 1'b0;
    for (int c = 1; c <= T + 30 && done_c == 0; c++) begin
      @(negedge clk);
      req_valid  = hold ? 1'($urandom_range(1, 0)) : 1'b0;
      req_period = 4'($urandom);
      if (busy !== 1'b1 || req_ready !== 1'b0) hs_bad = 1'b1;
      if (timer_we === 1'b1) begin
        wr_n++;
        checks++;
        if (wr_n == 1 && (c != 1 || timer_wdata !== {28'd0, p})) begin
          errors++; $display("FAIL %s write1: cycle %0d data %h want cycle 1 data %h", name, c, timer_wdata, {28'd0, p});
        end else if (wr_n == 2 && (c != exp_done - 1 || timer_wdata !== 32'd0)) begin
          errors++; $display("FAIL %s clear_write: cycle %0d data %h want cycle %0d data 0", name, c, timer_wdata, exp_done - 1);
        end
      end
      if (done === 1'b1) begin
        done_c  = c;
        to_seen = timed_out;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (done_c != exp_done) begin
      errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_c, exp_done);
    end
    checks++;
    if (to_seen !== exp_to) begin
      errors++; $display("FAIL %s timed_out: got %b want %b", name, to_seen, exp_to);
    end
    checks++;
    if (wr_n != exp_wr) begin
      errors++; $display("FAIL %s write_count: got %0d want %0d", name, wr_n, exp_wr);
    end
    checks++;
    if (hs_bad) begin
      errors++; $display("FAIL %s busy_ready: got glitch want busy=1 ready=0", name);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || timed_out !== exp_to) begin
      errors++; $display("FAIL %s after_done: got done=%b ready=%b to=%b want 0 1 %b", name, done, req_ready, timed_out, exp_to);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_period = 4'd0;
`ifdef TIMER_REQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_hs: got ready=%b busy=%b done=%b want 1 0 0", req_ready, busy, done);
    end
    checks++;
    if (timed_out !== 1'b0 || timer_we !== 1'b0 || timer_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_timer: got to=%b we=%b wdata=%h want 0 0 0", timed_out, timer_we, timer_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_req(4'd5, 6, 1'b0, "basic");
  endtask

  task automatic test_timeout();
    run_req(4'd3, 0, 1'b0, "timeout");
  endtask

  task automatic test_zero_period();
    run_req(4'd0, 0, 1'b0, "zero_period");
  endtask

  task automatic test_stale_end();
    @(negedge clk);
    stale_set = 1'b1;
    @(negedge clk);
    stale_set = 1'b0;
    run_req(4'd2, 4, 1'b0, "stale_end");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_req(4'($urandom_range(15, 0)), int'($urandom_range(24, 0)), 1'b1, "random");
    end
  endtask

  task automatic test_reset_mid_poll();
    int we_seen;
    run_req(4'd3, 0, 1'b0, "pre_reset_timeout");
    end_delay = 0;
    @(negedge clk);
    req_valid = 1'b1; req_period = 4'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    we_seen = 0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || timer_we !== 1'b0 || timed_out !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: got ready=%b busy=%b we=%b to=%b want 1 0 0 0", req_ready, busy, timer_we, timed_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (timer_we === 1'b1) we_seen++;
    end
    checks++;
    if (we_seen != 0) begin
      errors++; $display("FAIL mid_reset_no_clear: got %0d writes want 0", we_seen);
    end
    run_req(4'd7, 3, 1'b0, "after_reset");
  endtask

`ifdef TIMER_REQ_ABORT_EN
  task automatic test_abort();
    int clr_c, done_c;
    end_delay = 0;
    @(negedge clk);
    req_valid = 1'b1; req_period = 4'd9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    clr_c = 0; done_c = 0;
    for (int c = 1; c <= 5 && done_c == 0; c++) begin
      if (timer_we === 1'b1 && timer_wdata === 32'd0 && clr_c == 0) clr_c = c;
      if (done === 1'b1) done_c = c;
      if (done_c == 0) @(negedge clk);
    end
    checks++;
    if (clr_c != 1 || done_c != 2) begin
      errors++; $display("FAIL abort_seq: got clear@%0d done@%0d want 1 2", clr_c, done_c);
    end
    checks++;
    if (timed_out !== 1'b1) begin
      errors++; $display("FAIL abort_status: got %b want 1", timed_out);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_zero_period();
    test_stale_end();
    test_back_to_back();
    test_reset_mid_poll();
`ifdef TIMER_REQ_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
